// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_master_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_SETUP_ENC  = 2'd1;
    localparam logic [1:0] ST_ACCESS_ENC = 2'd2;
    localparam logic [1:0] ST_RESP_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_SETUP  = ST_SETUP_ENC,
        ST_ACCESS = ST_ACCESS_ENC,
        ST_RESP   = ST_RESP_ENC
    } state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-command valid/ready to APB master bridge; macro APB_MASTER_PREADY_EN adds pready wait states + timeout.
// Latency: rsp_valid 3 cycles after the cmd handshake with no wait states; one command per 4 cycles at best.
// Backpressure: cmd_ready only in IDLE (no queueing); RESP holds the response stable until rsp_ready.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              pclk,
    input  logic              p_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
`ifdef APB_MASTER_PREADY_EN
    input  logic              pready,
`endif
    input  logic [DATA_W-1:0] prdata
);

    // A zero timeout would make every access fail on its first cycle.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_e state_q, state_d;

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              access_done;
    logic              access_fin;

`ifdef APB_MASTER_PREADY_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;
    logic             access_err;
    logic             rsp_err_q, rsp_err_d;

    // Count ACCESS cycles spent waiting; give up on the TIMEOUT-th one.
    always_comb begin
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
        access_done = pready || timeout_hit;
        access_err  = !pready && timeout_hit;
        cnt_d       = '0;
        if (state_q == ST_ACCESS && !access_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Wait-state counter register.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without pready every ACCESS completes in its first cycle.
    assign access_done = 1'b1;
`endif

    // State register.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_valid)   state_d = ST_SETUP;
            ST_SETUP:                   state_d = ST_ACCESS;
            ST_ACCESS: if (access_done) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready)   state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Output logic: APB strobes follow the next state so they come straight off flops.
    always_comb begin
        cmd_ready   = (state_q == ST_IDLE);
        access_fin  = (state_q == ST_ACCESS) && access_done;
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        if (cmd_ready && cmd_valid) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
        end
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_PREADY_EN
        rsp_err_d = rsp_err_q;
        if (access_fin) begin
            rsp_rdata_d = (pwrite_q || access_err) ? '0 : prdata;
            rsp_err_d   = access_err;
        end
`else
        if (access_fin) begin
            rsp_rdata_d = pwrite_q ? '0 : prdata;
        end
`endif
    end

    // Registered outputs.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_PREADY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_PREADY_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef APB_MASTER_PREADY_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
